fxp_div_stream: RTL and testbench

- Fixed-point stream divider, the inverse companion of mod4_mult: output_tdata = input_tdata_a / input_tdata_b.
- Same i/f/sign parameter set and the same valid/ready stream ports as mod4_mult, so both blocks drop into the same datapaths and benches.
- Iterative restoring divider producing one quotient bit per cycle, with an overflow flag and divide-by-zero handling.

---
 rtl/fxp_pkg.sv | 27 ++
 rtl/fxp_udiv_core.sv | 71 +++++++
 rtl/fxp_div_stream.sv | 176 +++++++++++++++++
 tb/tb_fxp_div_stream.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared state type and width/limit helpers for the fixed-point stream divider.
package fxp_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, HOLD} state_e;

  function automatic int W(input int i, input int f);
    return i + f;
  endfunction

  function automatic int fxpNw(input int i1, input int f2, input int f3);
    return i1 + f2 + f3;
  endfunction

  // Limits come back as 64-bit magnitudes so wide quotients can be compared directly.
  function automatic logic [63:0] signedMax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] signedMinMag(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] unsignedMax(input int w);
    return (w >= 64) ? {64{1'b1}} : (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/fxp_udiv_core.sv
// Unsigned restoring divider: one quotient bit per cycle, NW cycles after start.
module fxp_udiv_core #(
  parameter int NW = 30,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [NW-1:0] num_i,
  input  logic [DW-1:0] den_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [NW-1:0] quo_o,
  output logic          dz_o
);

  localparam int CW = $clog2(NW + 1);

  logic [NW-1:0] num_q;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] den_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;

  logic [DW:0]   remShift_d;
  logic [DW-1:0] remSub_d;
  logic          qBit_d;

  // The dividend register doubles as the quotient register: bits shift out at the top, quotient bits in at the bottom.
  always_comb begin
    remShift_d = {rem_q, num_q[NW-1]};
    qBit_d     = (remShift_d >= {1'b0, den_q});
    remSub_d   = remShift_d[DW-1:0] - den_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      num_q  <= num_i;
      den_q  <= den_i;
      rem_q  <= '0;
      cnt_q  <= CW'(NW - 1);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        rem_q <= qBit_d ? remSub_d : remShift_d[DW-1:0];
        num_q <= {num_q[NW-2:0], qBit_d};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quo_o  = num_q;
  assign dz_o   = (den_q == '0);

endmodule

// File: rtl/fxp_div_stream.sv
// Fixed-point stream divider (quotient = a / b) with joined valid/ready inputs and overflow flag.
// Define FXP_DIV_SAT_EN to saturate overflowing quotients instead of wrapping them.
module fxp_div_stream
  import fxp_pkg::*;
#(
  parameter int i1    = 2,
  parameter int f1    = 14,
  parameter int i2    = 2,
  parameter int f2    = 14,
  parameter int i3    = 2,
  parameter int f3    = 14,
  parameter int sign1 = 1,
  parameter int sign2 = 1,
  parameter int osign = ((sign1 != 0) || (sign2 != 0)) ? 1 : 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [i1+f1-1:0]   input_tdata_a,
  input  logic               input_tvalid_a,
  output logic               input_tready_a,
  input  logic [i2+f2-1:0]   input_tdata_b,
  input  logic               input_tvalid_b,
  output logic               input_tready_b,
  output logic [i3+f3-1:0]   output_tdata,
  output logic               output_tvalid,
  input  logic               output_tready,
  output logic               overflow
);

  localparam int W1 = W(i1, f1);
  localparam int W2 = W(i2, f2);
  localparam int W3 = W(i3, f3);
  localparam int NW = fxpNw(i1, f2, f3);
  localparam int SH = f2 + f3 - f1;
  localparam int CW = $clog2(NW + 1);

  localparam logic [63:0] POS_MAX = signedMax(W3);
  localparam logic [63:0] NEG_MAG = signedMinMag(W3);
  localparam logic [63:0] UNS_MAX = unsignedMax(W3);
  localparam logic [W3-1:0] SAT_HI = (osign != 0) ? POS_MAX[W3-1:0] : UNS_MAX[W3-1:0];
  localparam logic [W3-1:0] SAT_LO = NEG_MAG[W3-1:0];

  if (f2 + f3 < f1) begin : gBadFrac
    $error("fxp_div_stream: f2+f3 must be >= f1");
  end
  if (osign != (((sign1 != 0) || (sign2 != 0)) ? 1 : 0)) begin : gBadSign
    $error("fxp_div_stream: osign must equal (sign1 || sign2)");
  end

  state_e        state_q;
  logic          ready_q;
  logic          valid_q;
  logic          ovf_q;
  logic [W3-1:0] data_q;
  logic          neg_q;
  logic          negA_q;
  logic [CW-1:0] cnt_q;

  logic          signA_d;
  logic          signB_d;
  logic [W1-1:0] magA_d;
  logic [W2-1:0] magB_d;
  logic [NW-1:0] num_d;
  logic          accept_d;

  logic          coreBusy;
  logic          coreDone;
  logic [NW-1:0] coreQuo;
  logic          coreDz;

  logic [63:0]   quoWide_d;
  logic [W3-1:0] quoLow_d;
  logic [W3-1:0] res_d;
  logic          ovf_d;

  always_comb begin
    signA_d  = (sign1 != 0) && input_tdata_a[W1-1];
    signB_d  = (sign2 != 0) && input_tdata_b[W2-1];
    magA_d   = signA_d ? -input_tdata_a : input_tdata_a;
    magB_d   = signB_d ? -input_tdata_b : input_tdata_b;
    num_d    = NW'(magA_d) << SH;
    accept_d = ready_q && input_tvalid_a && input_tvalid_b && !coreBusy;
  end

  fxp_udiv_core #(
    .NW(NW),
    .DW(W2)
  ) uCore (
    .clk    (clk),
    .reset  (reset),
    .start_i(accept_d),
    .num_i  (num_d),
    .den_i  (magB_d),
    .busy_o (coreBusy),
    .done_o (coreDone),
    .quo_o  (coreQuo),
    .dz_o   (coreDz)
  );

  // Negating only the low W3 bits gives the same wrapped pattern as negating the full quotient.
  always_comb begin
    quoWide_d = 64'(coreQuo);
    quoLow_d  = W3'(coreQuo);
    res_d     = neg_q ? -quoLow_d : quoLow_d;
    if (osign != 0) begin
      ovf_d = neg_q ? (quoWide_d > NEG_MAG) : (quoWide_d > POS_MAX);
    end else begin
      ovf_d = (quoWide_d > UNS_MAX);
    end
`ifdef FXP_DIV_SAT_EN
    if (ovf_d) begin
      res_d = neg_q ? SAT_LO : SAT_HI;
    end
`endif
    if (coreDz) begin
      ovf_d = 1'b1;
      res_d = negA_q ? SAT_LO : SAT_HI;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      neg_q   <= 1'b0;
      negA_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept_d) begin
            ready_q <= 1'b0;
            neg_q   <= signA_d ^ signB_d;
            negA_q  <= signA_d;
            cnt_q   <= CW'(NW - 1);
            state_q <= CALC;
          end
        end
        CALC: begin
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          if (coreDone) begin
            data_q  <= res_d;
            ovf_q   <= ovf_d;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (output_tready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign input_tready_a = ready_q;
  assign input_tready_b = ready_q;
  assign output_tdata   = data_q;
  assign output_tvalid  = valid_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_fxp_div_stream.sv
// Directed bench for fxp_div_stream at the default Q2.14 parameters.
// Overflow data expectations follow FXP_DIV_SAT_EN when the bench is built with it.
module tb_fxp_div_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] input_tdata_a;
  logic        input_tvalid_a;
  logic        input_tready_a;
  logic [15:0] input_tdata_b;
  logic        input_tvalid_b;
  logic        input_tready_b;
  logic [15:0] output_tdata;
  logic        output_tvalid;
  logic        output_tready;
  logic        overflow;

  int errors = 0;
  int checks = 0;

`ifdef FXP_DIV_SAT_EN
  localparam logic [15:0] OVF_POS_EXP = 16'h7FFF;
  localparam logic [15:0] OVF_NEG_EXP = 16'h8000;
`else
  localparam logic [15:0] OVF_POS_EXP = 16'h8000;
  localparam logic [15:0] OVF_NEG_EXP = 16'h0000;
`endif

  always #5 clk = ~clk;

  fxp_div_stream dut (
    .clk           (clk),
    .reset         (reset),
    .input_tdata_a (input_tdata_a),
    .input_tvalid_a(input_tvalid_a),
    .input_tready_a(input_tready_a),
    .input_tdata_b (input_tdata_b),
    .input_tvalid_b(input_tvalid_b),
    .input_tready_b(input_tready_b),
    .output_tdata  (output_tdata),
    .output_tvalid (output_tvalid),
    .output_tready (output_tready),
    .overflow      (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand pair, waits for the result beat and optionally consumes it.
  task automatic runOp(input logic [15:0] a, input logic [15:0] b, input bit consume,
                       output logic [15:0] d, output logic o, output int lat, output int waitN);
    input_tdata_a  = a;
    input_tdata_b  = b;
    input_tvalid_a = 1'b1;
    input_tvalid_b = 1'b1;
    waitN = 0;
    while (!(input_tready_a && input_tready_b) && waitN < 100) begin
      tick();
      waitN++;
    end
    tick();
    input_tvalid_a = 1'b0;
    input_tvalid_b = 1'b0;
    lat = 0;
    while (!output_tvalid && lat < 200) begin
      tick();
      lat++;
    end
    if (!output_tvalid) lat = -1;
    d = output_tdata;
    o = overflow;
    if (consume) begin
      output_tready = 1'b1;
      tick();
      output_tready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    input_tdata_a  = '0;
    input_tdata_b  = '0;
    input_tvalid_a = 1'b0;
    input_tvalid_b = 1'b0;
    output_tready  = 1'b0;
    tick();
    tick();
    checks++;
    if ({input_tready_a, input_tready_b, output_tvalid, overflow, output_tdata} !== 20'h0)
      $display("[TB] FAIL reset outputs: got rdy=%b%b vld=%b ovf=%b data=%h, expected all 0",
               input_tready_a, input_tready_b, output_tvalid, overflow, output_tdata);
    reset = 1'b0;
    #1;
    checks++;
    if (input_tready_a !== 1'b0 || input_tready_b !== 1'b0)
      $display("[TB] FAIL ready before first edge: got %b%b expected 00", input_tready_a, input_tready_b);
    tick();
    checks++;
    if (input_tready_a !== 1'b1 || input_tready_b !== 1'b1)
      $display("[TB] FAIL ready after first edge: got %b%b expected 11", input_tready_a, input_tready_b);
    errors += (input_tready_a !== 1'b1 || input_tready_b !== 1'b1) ? 1 : 0;
  endtask

  task automatic test_basic();
    logic [15:0] d;
    logic        o;
    int          lat, w;
    runOp(16'h3000, 16'h6000, 1'b1, d, o, lat, w);
    checks++;
    if (d !== 16'h2000) begin errors++; $display("[TB] FAIL basic data: got %h expected 2000", d); end
    checks++;
    if (o !== 1'b0) begin errors++; $display("[TB] FAIL basic overflow: got %b expected 0", o); end
    checks++;
    if (lat != 31) begin errors++; $display("[TB] FAIL basic latency: got %0d expected 31", lat); end
    checks++;
    if (w != 0) begin errors++; $display("[TB] FAIL basic accept wait: got %0d expected 0", w); end
  endtask

  logic [15:0] sgnA   [6] = '{16'hE000, 16'h2000, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF};
  logic [15:0] sgnB   [6] = '{16'h1000, 16'hF000, 16'h8000, 16'h4000, 16'h6000, 16'h6000};
  logic [15:0] sgnExp [6] = '{16'h8000, 16'h8000, 16'h4000, 16'h7FFF, 16'h0000, 16'h0000};

  task automatic test_signed();
    logic [15:0] d;
    logic        o;
    int          lat, w;
    for (int i = 0; i < 6; i++) begin
      runOp(sgnA[i], sgnB[i], 1'b1, d, o, lat, w);
      checks++;
      if (d !== sgnExp[i] || lat != 31) begin
        errors++;
        $display("[TB] FAIL signed[%0d] %h/%h: got %h lat %0d expected %h lat 31",
                 i, sgnA[i], sgnB[i], d, lat, sgnExp[i]);
      end
      checks++;
      if (o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL signed[%0d] overflow: got %b expected 0", i, o);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    logic        o;
    int          lat, w;
    runOp(16'h2000, 16'h1000, 1'b1, d, o, lat, w);
    checks++;
    if (o !== 1'b1 || d !== OVF_POS_EXP) begin
      errors++;
      $display("[TB] FAIL overflow pos: got ovf=%b data=%h expected ovf=1 data=%h", o, d, OVF_POS_EXP);
    end
    runOp(16'hC000, 16'h0800, 1'b1, d, o, lat, w);
    checks++;
    if (o !== 1'b1 || d !== OVF_NEG_EXP) begin
      errors++;
      $display("[TB] FAIL overflow neg: got ovf=%b data=%h expected ovf=1 data=%h", o, d, OVF_NEG_EXP);
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] d;
    logic        o;
    int          lat, w;
    runOp(16'h1000, 16'h0000, 1'b1, d, o, lat, w);
    checks++;
    if (o !== 1'b1 || d !== 16'h7FFF || lat != 31) begin
      errors++;
      $display("[TB] FAIL divzero pos: got ovf=%b data=%h lat=%0d expected ovf=1 data=7fff lat=31", o, d, lat);
    end
    runOp(16'hF000, 16'h0000, 1'b1, d, o, lat, w);
    checks++;
    if (o !== 1'b1 || d !== 16'h8000) begin
      errors++;
      $display("[TB] FAIL divzero neg: got ovf=%b data=%h expected ovf=1 data=8000", o, d);
    end
    runOp(16'h0000, 16'h0000, 1'b1, d, o, lat, w);
    checks++;
    if (o !== 1'b1 || d !== 16'h7FFF) begin
      errors++;
      $display("[TB] FAIL divzero zero: got ovf=%b data=%h expected ovf=1 data=7fff", o, d);
    end
  endtask

  task automatic test_valid_skew();
    logic [15:0] d;
    logic        o;
    int          lat, w;
    int          consumed;
    input_tdata_a  = 16'h3000;
    input_tdata_b  = 16'h0000;
    input_tvalid_a = 1'b1;
    input_tvalid_b = 1'b0;
    consumed = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (input_tready_a !== 1'b1 || input_tready_b !== 1'b1 || output_tvalid !== 1'b0) consumed++;
    end
    checks++;
    if (consumed != 0) begin
      errors++;
      $display("[TB] FAIL skew lone valid: got %0d cycles with consumption, expected 0", consumed);
    end
    runOp(16'h3000, 16'h6000, 1'b1, d, o, lat, w);
    checks++;
    if (d !== 16'h2000 || o !== 1'b0 || lat != 31 || w != 0) begin
      errors++;
      $display("[TB] FAIL skew result: got data=%h ovf=%b lat=%0d wait=%0d expected 2000 0 31 0", d, o, lat, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic        o;
    int          lat, w;
    int          unstable;
    runOp(16'h1800, 16'h6000, 1'b0, d, o, lat, w);
    checks++;
    if (d !== 16'h1000 || o !== 1'b0 || lat != 31) begin
      errors++;
      $display("[TB] FAIL backpressure beat: got data=%h ovf=%b lat=%0d expected 1000 0 31", d, o, lat);
    end
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (output_tvalid !== 1'b1 || output_tdata !== 16'h1000 || overflow !== 1'b0 ||
          input_tready_a !== 1'b0 || input_tready_b !== 1'b0) unstable++;
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("[TB] FAIL backpressure hold: got %0d unstable cycles expected 0", unstable);
    end
    output_tready = 1'b1;
    tick();
    output_tready = 1'b0;
    checks++;
    if (output_tvalid !== 1'b0 || input_tready_a !== 1'b1 || input_tready_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release: got vld=%b rdy=%b%b expected vld=0 rdy=11",
               output_tvalid, input_tready_a, input_tready_b);
    end
    runOp(16'h3000, 16'h6000, 1'b1, d, o, lat, w);
    checks++;
    if (w != 0 || lat != 31 || d !== 16'h2000) begin
      errors++;
      $display("[TB] FAIL back-to-back: got wait=%0d lat=%0d data=%h expected 0 31 2000", w, lat, d);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] d;
    logic        o;
    int          lat, w;
    int          stale;
    input_tdata_a  = 16'h7FFF;
    input_tdata_b  = 16'h1000;
    input_tvalid_a = 1'b1;
    input_tvalid_b = 1'b1;
    tick();
    input_tvalid_a = 1'b0;
    input_tvalid_b = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({input_tready_a, input_tready_b, output_tvalid, overflow, output_tdata} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL mid-reset outputs: got rdy=%b%b vld=%b ovf=%b data=%h expected all 0",
               input_tready_a, input_tready_b, output_tvalid, overflow, output_tdata);
    end
    tick();
    tick();
    reset = 1'b0;
    stale = 0;
    repeat (40) begin
      tick();
      if (output_tvalid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("[TB] FAIL mid-reset stale beat: got %0d valid cycles expected 0", stale);
    end
    runOp(16'h3000, 16'h6000, 1'b1, d, o, lat, w);
    checks++;
    if (d !== 16'h2000 || o !== 1'b0 || lat != 31) begin
      errors++;
      $display("[TB] FAIL after mid-reset: got data=%h ovf=%b lat=%0d expected 2000 0 31", d, o, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, d;
    logic        o;
    int          lat, w, tries;
    real         ra, rb, q, got, err;
    for (int i = 0; i < 10; i++) begin
      tries = 0;
      do begin
        a  = 16'($urandom);
        b  = 16'($urandom);
        ra = $itor($signed(a)) / 16384.0;
        rb = $itor($signed(b)) / 16384.0;
        q  = (b != 16'h0) ? ra / rb : 100.0;
        tries++;
      end while (((q < 0.0) ? -q : q) >= 1.9 && tries < 1000);
      runOp(a, b, 1'b1, d, o, lat, w);
      got = $itor($signed(d)) / 16384.0;
      err = got - q;
      if (err < 0.0) err = -err;
      checks++;
      if (o !== 1'b0 || err >= 1.0e-4 || lat != 31) begin
        errors++;
        $display("[TB] FAIL random[%0d] %h/%h: got data=%h ovf=%b lat=%0d expected ~%f ovf=0 lat=31",
                 i, a, b, d, o, lat, q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_div_zero();
    test_valid_skew();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
